// File: rtl/vpe_pkg.sv
// vpe_pkg: opcodes, FSM states and lane/legality helpers shared by the vector PE.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vpe_pkg;

    localparam logic [7:0] OP_VADD     = 8'h00;
    localparam logic [7:0] OP_VMUL     = 8'h01;
    localparam logic [7:0] OP_VDOT     = 8'h02;
    localparam logic [7:0] OP_VADDVARP = 8'h03;
    localparam logic [7:0] OP_VMULVARP = 8'h04;
    localparam logic [7:0] OP_VDOTVARP = 8'h05;
    localparam logic [7:0] OP_VSUB     = 8'h06;
    localparam logic [7:0] OP_VSUBVARP = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_RESP = 2'd2
    } vpe_state_e;

    typedef struct packed {
        logic sew_ok;
        logic vap_ok;
    } vpe_legal_t;

    // Number of lanes of width w in an xlen datapath; 0 for unsupported widths.
    function automatic int vpe_lanes(input int w, input int xlen);
        int n;
        case (w)
            8:       n = xlen / 8;
            16:      n = xlen / 16;
            32:      n = xlen / 32;
            64:      n = xlen / 64;
            default: n = 0;
        endcase
        return n;
    endfunction

    // Element-width and varp-precision legality for a given datapath width.
    function automatic vpe_legal_t vpe_legal(input logic [9:0] sew, input logic [3:0] vap,
                                             input int xlen);
        vpe_legal_t r;
        r.sew_ok = (sew == 10'd8) || (sew == 10'd16) || (sew == 10'd32) ||
                   ((sew == 10'd64) && (xlen == 64));
        r.vap_ok = (vap == 4'd1) || (vap == 4'd2) || (vap == 4'd4) || (vap == 4'd8);
        return r;
    endfunction

    // Sign-extend the low w bits of v to 65 bits.
    function automatic logic signed [64:0] vpe_sext(input logic [63:0] v, input int w);
        logic signed [64:0] t;
        t = signed'({1'b0, v} << (65 - w));
        return t >>> (65 - w);
    endfunction

endpackage

// File: rtl/vpe_bitserial_mul.sv
// vpe_bitserial_mul: lane-segmented signed MSB-first serial multiplier, one B bit per enabled cycle.
// Latency: nbits enabled cycles; prod is the value the accumulator takes at the current step.
// Backpressure: none; the caller holds en for exactly nbits cycles and watches last.
module vpe_bitserial_mul #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [6:0]      lane_w,
    input  logic [6:0]      nbits,
    input  logic            vap1,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] prod,
    output logic            last
);
    import vpe_pkg::*;

    logic [6:0]      cnt;
    logic [XLEN-1:0] acc;
    int              w;
    logic [63:0]     msk;
    logic [63:0]     lane_a;
    logic [63:0]     lane_acc;
    logic [63:0]     lane_b;
    logic [64:0]     sa;
    logic [64:0]     p;

    // Step counter runs while enabled and rewinds as soon as the multiplier goes idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   cnt <= '0;
        else if (en) cnt <= cnt + 7'd1;
        else         cnt <= '0;
    end

    // Partial products advance one B bit per enabled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   acc <= '0;
        else if (en) acc <= prod;
    end

    assign last = en && (cnt == nbits - 7'd1);

    // Per-lane step: seed from the lane's B MSB on step 0, shift-and-add afterwards.
    always_comb begin
        prod     = '0;
        w        = int'(lane_w);
        msk      = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        lane_a   = '0;
        lane_acc = '0;
        lane_b   = '0;
        sa       = '0;
        p        = '0;
        for (int l = 0; l < XLEN / 8; l++) begin
            if (l < vpe_lanes(w, XLEN)) begin
                lane_a   = 64'(a >> (l * w));
                lane_acc = 64'(acc >> (l * w));
                lane_b   = 64'(b >> (l * w + w - 1 - int'(cnt)));
                sa       = vpe_sext(lane_a, w);
                if (cnt == 7'd0)
                    // A single-bit multiplier encodes +1/-1 rather than 0/-1.
                    p = lane_b[0] ? (65'd0 - sa) : (vap1 ? sa : 65'd0);
                else
                    p = {lane_acc, 1'b0} + (lane_b[0] ? sa : 65'd0);
                prod = prod | XLEN'((p[63:0] & msk) << (l * w));
            end
        end
    end

endmodule

// File: rtl/vector_pe_gen.sv
// vector_pe_gen: SIMD lane PE for add/sub/mul/dot (full and varp); define VPE_SAT_EN to clamp add/sub/accumulate.
// Latency: out_valid 1 cycle after accept for add/sub/illegal, N+1 for mul/dot (N = sew, or vap for varp).
// Backpressure: in_ready only in IDLE; RESP holds peout/err/out_valid until out_ready.
module vector_pe_gen #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      instr,
    input  logic [9:0]      sew,
    input  logic [3:0]      vap,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic [XLEN-1:0] opc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] peout,
    output logic            err
);
    import vpe_pkg::*;

    vpe_state_e      state, state_nx;
    logic            accept;
    logic [7:0]      instr_r;
    logic [6:0]      sew_r;
    logic [3:0]      vap_r;
    logic [XLEN-1:0] opa_r, opb_r, opc_r;
    logic [XLEN-1:0] peout_r;
    logic            err_r;
    vpe_legal_t      legal;
    logic            varp_in, mul_in, sub_in, illegal_in;
    int              w_in;
    logic [XLEN-1:0] b_in, add_res;
    logic            varp_r, dot_r, vap1_r, mul_last;
    logic [6:0]      w_r, nbits_r;
    logic [XLEN-1:0] prod, dot_res;

    // Lane-wise add/sub of width w with no carries across lanes; clamps when saturation is built in.
    function automatic logic [XLEN-1:0] lane_addsub(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                    input logic sub, input int w);
        logic [XLEN-1:0]    r;
        logic [63:0]        msk;
        logic signed [64:0] sa, sb, s;
`ifdef VPE_SAT_EN
        logic signed [64:0] maxv, minv;
`endif
        r   = '0;
        msk = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        for (int l = 0; l < XLEN / 8; l++) begin
            if (l < vpe_lanes(w, XLEN)) begin
                sa = vpe_sext(64'(a >> (l * w)), w);
                sb = vpe_sext(64'(b >> (l * w)), w);
                s  = sub ? (sa - sb) : (sa + sb);
`ifdef VPE_SAT_EN
                maxv = (65'sd1 <<< (w - 1)) - 65'sd1;
                minv = -(65'sd1 <<< (w - 1));
                if (s > maxv)      s = maxv;
                else if (s < minv) s = minv;
`endif
                r = r | XLEN'((64'(s) & msk) << (l * w));
            end
        end
        return r;
    endfunction

    // Keep only the top v bits of each B byte, sign-extended into the byte.
    function automatic logic [XLEN-1:0] varp_bytes(input logic [XLEN-1:0] b, input logic [3:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < XLEN / 8; i++)
            r[i*8 +: 8] = 8'($signed(b[i*8 +: 8]) >>> (4'd8 - v));
        return r;
    endfunction

    // Decode the request on the input side; add/sub results are ready at acceptance.
    always_comb begin
        legal      = vpe_legal(sew, vap, XLEN);
        varp_in    = (instr == OP_VADDVARP) || (instr == OP_VMULVARP) ||
                     (instr == OP_VDOTVARP) || (instr == OP_VSUBVARP);
        mul_in     = (instr == OP_VMUL) || (instr == OP_VDOT) ||
                     (instr == OP_VMULVARP) || (instr == OP_VDOTVARP);
        sub_in     = (instr == OP_VSUB) || (instr == OP_VSUBVARP);
        illegal_in = (instr > OP_VSUBVARP) || (varp_in ? !legal.vap_ok : !legal.sew_ok);
        w_in       = (varp_in || illegal_in) ? 8 : int'(sew);
        b_in       = varp_in ? varp_bytes(opb, vap) : opb;
        add_res    = lane_addsub(opa, b_in, sub_in, w_in);
    end

    assign varp_r  = (instr_r == OP_VMULVARP) || (instr_r == OP_VDOTVARP);
    assign dot_r   = (instr_r == OP_VDOT) || (instr_r == OP_VDOTVARP);
    assign w_r     = varp_r ? 7'd8 : sew_r;
    assign nbits_r = varp_r ? {3'b000, vap_r} : sew_r;
    assign vap1_r  = varp_r && (vap_r == 4'd1);
    assign dot_res = lane_addsub(prod, opc_r, 1'b0, int'(w_r));

    vpe_bitserial_mul #(.XLEN(XLEN)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .en     (state == ST_MULT),
        .lane_w (w_r),
        .nbits  (nbits_r),
        .vap1   (vap1_r),
        .a      (opa_r),
        .b      (opb_r),
        .prod   (prod),
        .last   (mul_last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state and handshake decode; in_ready is held low while reset is asserted.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !reset;
                accept   = in_valid && !reset;
                if (accept) state_nx = (mul_in && !illegal_in) ? ST_MULT : ST_RESP;
            end
            ST_MULT: begin
                if (mul_last) state_nx = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand capture at acceptance and result load; the result is frozen through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_r <= '0;
            sew_r   <= '0;
            vap_r   <= '0;
            opa_r   <= '0;
            opb_r   <= '0;
            opc_r   <= '0;
            peout_r <= '0;
            err_r   <= 1'b0;
        end else if (accept) begin
            instr_r <= instr;
            sew_r   <= sew[6:0];
            vap_r   <= vap;
            opa_r   <= opa;
            opb_r   <= opb;
            opc_r   <= opc;
            err_r   <= illegal_in;
            peout_r <= (illegal_in || mul_in) ? '0 : add_res;
        end else if ((state == ST_MULT) && mul_last) begin
            peout_r <= dot_r ? dot_res : prod;
        end
    end

    assign peout = peout_r;
    assign err   = err_r;

endmodule

// File: tb/tb_vector_pe_gen.sv
// tb_vector_pe_gen: directed self-checking bench for vector_pe_gen at XLEN=32.
// Latency: checks response cycle counts against hand-computed values.
// Backpressure: exercises out_ready stalls and the RESP/in_valid overlap.
module tb_vector_pe_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  instr = '0;
    logic [9:0]  sew = '0;
    logic [3:0]  vap = '0;
    logic [31:0] opa = '0, opb = '0, opc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] peout;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  op;
        logic [9:0]  sew;
        logic [3:0]  vap;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] want;
        int          lat;
    } vec_t;

    vector_pe_gen #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .sew       (sew),
        .vap       (vap),
        .opa       (opa),
        .opb       (opb),
        .opc       (opc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .peout     (peout),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Present one request for one edge, then scramble inputs to prove they were latched.
    task automatic issue(input logic [7:0] i, input logic [9:0] s, input logic [3:0] v,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        instr = i; sew = s; vap = v; opa = a; opb = b; opc = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        instr = 8'hFF; sew = 10'd0; vap = 4'd0;
        opa = 32'hDEADBEEF; opb = 32'h5A5A5A5A; opc = 32'h12345678;
    endtask

    // Cycles from acceptance until out_valid, bounded.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        checks++; if (peout !== 32'h0) begin errors++; $display("FAIL reset peout: got %h want 0", peout); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_illegal();
        vec_t v[4];
        int   lat;
        v[0] = '{8'h00, 10'd12, 4'd1, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 1};
        v[1] = '{8'h08, 10'd8,  4'd1, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 1};
        v[2] = '{8'h04, 10'd8,  4'd3, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 1};
        v[3] = '{8'h01, 10'd64, 4'd1, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 1};
        for (int k = 0; k < 4; k++) begin
            issue(v[k].op, v[k].sew, v[k].vap, v[k].a, v[k].b, v[k].c);
            wait_resp(lat);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL illegal[%0d] out_valid: got %b want 1", k, out_valid); end
            checks++; if (lat != v[k].lat) begin errors++; $display("FAIL illegal[%0d] latency: got %0d want %0d", k, lat, v[k].lat); end
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal[%0d] err: got %b want 1", k, err); end
            checks++; if (peout !== v[k].want) begin errors++; $display("FAIL illegal[%0d] peout: got %h want %h", k, peout, v[k].want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_arith();
        vec_t v[5];
        int   lat;
`ifdef VPE_SAT_EN
        v[0] = '{8'h00, 10'd8,  4'd0, 32'h7F010203, 32'h01010101, 32'h0, 32'h7F020304, 1};
        v[1] = '{8'h06, 10'd16, 4'd0, 32'h80000005, 32'h00010007, 32'h0, 32'h8000FFFE, 1};
        v[4] = '{8'h07, 10'd8,  4'd8, 32'h10203040, 32'h01FF0280, 32'h0, 32'h0F212E7F, 1};
`else
        v[0] = '{8'h00, 10'd8,  4'd0, 32'h7F010203, 32'h01010101, 32'h0, 32'h80020304, 1};
        v[1] = '{8'h06, 10'd16, 4'd0, 32'h80000005, 32'h00010007, 32'h0, 32'h7FFFFFFE, 1};
        v[4] = '{8'h07, 10'd8,  4'd8, 32'h10203040, 32'h01FF0280, 32'h0, 32'h0F212EC0, 1};
`endif
        v[2] = '{8'h03, 10'd0,  4'd4, 32'h10101010, 32'hF080701F, 32'h0, 32'h0F081711, 1};
        v[3] = '{8'h06, 10'd32, 4'd0, 32'h00000005, 32'h00000007, 32'h0, 32'hFFFFFFFE, 1};
        for (int k = 0; k < 5; k++) begin
            issue(v[k].op, v[k].sew, v[k].vap, v[k].a, v[k].b, v[k].c);
            wait_resp(lat);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arith[%0d] out_valid: got %b want 1", k, out_valid); end
            checks++; if (lat != v[k].lat) begin errors++; $display("FAIL arith[%0d] latency: got %0d want %0d", k, lat, v[k].lat); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL arith[%0d] err: got %b want 0", k, err); end
            checks++; if (peout !== v[k].want) begin errors++; $display("FAIL arith[%0d] peout: got %h want %h", k, peout, v[k].want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mul();
        vec_t v[7];
        int   lat;
        v[0] = '{8'h01, 10'd16, 4'd0, 32'hFFFD0003, 32'h00050004, 32'h0,        32'hFFF1000C, 17};
        v[1] = '{8'h02, 10'd8,  4'd0, 32'h02FF0310, 32'h03020405, 32'h01020304, 32'h07000F54, 9};
        v[2] = '{8'h05, 10'd0,  4'd2, 32'h05050505, 32'hC0404080, 32'h01010101, 32'hFC0606F7, 3};
        v[3] = '{8'h04, 10'd0,  4'd1, 32'h03030303, 32'h80000080, 32'h0,        32'hFD0303FD, 2};
        v[4] = '{8'h01, 10'd32, 4'd0, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'hFFFFFFFA, 33};
        v[5] = '{8'h04, 10'd0,  4'd4, 32'h07070707, 32'h7080F010, 32'h0,        32'h31C8F907, 5};
`ifdef VPE_SAT_EN
        v[6] = '{8'h02, 10'd8,  4'd0, 32'h7F000000, 32'h01000000, 32'h01000000, 32'h7F000000, 9};
`else
        v[6] = '{8'h02, 10'd8,  4'd0, 32'h7F000000, 32'h01000000, 32'h01000000, 32'h80000000, 9};
`endif
        for (int k = 0; k < 7; k++) begin
            issue(v[k].op, v[k].sew, v[k].vap, v[k].a, v[k].b, v[k].c);
            wait_resp(lat);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul[%0d] out_valid: got %b want 1", k, out_valid); end
            checks++; if (lat != v[k].lat) begin errors++; $display("FAIL mul[%0d] latency: got %0d want %0d", k, lat, v[k].lat); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL mul[%0d] err: got %b want 0", k, err); end
            checks++; if (peout !== v[k].want) begin errors++; $display("FAIL mul[%0d] peout: got %h want %h", k, peout, v[k].want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        issue(8'h00, 10'd8, 4'd0, 32'h01020304, 32'h01010101, 32'h0);
        wait_resp(lat);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp out_valid: got %b want 1", out_valid); end
        // A competing request is offered throughout the stall.
        instr = 8'h00; sew = 10'd8; vap = 4'd0; opa = 32'h10101010; opb = 32'h01010101; opc = 32'h0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp hold[%0d] out_valid: got %b want 1", k, out_valid); end
            checks++; if (peout !== 32'h02030405) begin errors++; $display("FAIL bp hold[%0d] peout: got %h want 02030405", k, peout); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp hold[%0d] in_ready: got %b want 0", k, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp release in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp idle out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp idle in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp second out_valid: got %b want 1", out_valid); end
        checks++; if (peout !== 32'h11111111) begin errors++; $display("FAIL bp second peout: got %h want 11111111", peout); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mult();
        int seen;
        int lat;
        issue(8'h01, 10'd32, 4'd0, 32'hFFFFFFFE, 32'h00000003, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset release in_ready: got %b want 1", in_ready); end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset stray out_valid: got %0d cycles want 0", seen); end
        issue(8'h00, 10'd8, 4'd0, 32'h01020304, 32'h01010101, 32'h0);
        wait_resp(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL midreset recover latency: got %0d want 1", lat); end
        checks++; if (peout !== 32'h02030405) begin errors++; $display("FAIL midreset recover peout: got %h want 02030405", peout); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_arith();
        test_mul();
        test_backpressure();
        test_reset_mid_mult();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
